// File: rtl/eip_sequencer.sv
// eip_sequencer: owns the Tiny86 architectural EIP and steps each instruction
// through fetch, execute and retire. It also handles single-step pause, halt,
// the watchdog fault and the retired-instruction counter.
module eip_sequencer #(
   parameter logic [31:0] RESET_EIP = 32'h0000_0000,
   parameter int unsigned TIMEOUT   = 16,
   parameter int unsigned CNT_W     = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        single_step,
   output logic        fetch_req,
   output logic [31:0] fetch_addr,
   input  logic        fetch_ack,
   input  logic [3:0]  fetch_len,
   input  logic        fetch_halt,
   output logic        exec_req,
   input  logic        exec_done,
   input  logic [31:0] cfu_next_eip,
   output logic [31:0] eip,
   output logic [3:0]  instr_len,
   output logic        retired,
   output logic [31:0] retire_count,
   output logic        halted,
   output logic        fault,
   output logic [1:0]  fault_code
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_EXEC,
      S_RETIRE,
      S_PAUSE,
      S_HALT,
      S_FAULT
   } state_t;

   localparam logic [1:0] FC_NONE       = 2'd0;
   localparam logic [1:0] FC_FETCH_TO   = 2'd1;
   localparam logic [1:0] FC_ZERO_LEN   = 2'd2;
   localparam logic [1:0] FC_EXEC_TO    = 2'd3;

   // Watchdog value on the last allowed waiting cycle; an ack on this cycle still wins.
   localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

   state_t            state_q, state_d;
   logic [31:0]       eip_q, eip_d;
   logic [31:0]       next_eip_q, next_eip_d;
   logic [3:0]        instr_len_q, instr_len_d;
   logic [31:0]       retire_count_q, retire_count_d;
   logic [CNT_W-1:0]  wd_q, wd_d;
   logic [1:0]        fault_code_q, fault_code_d;
   logic              fetch_req_q, fetch_req_d;
   logic              exec_req_q, exec_req_d;
   logic              retired_q, retired_d;
   logic              halted_q, halted_d;
   logic              fault_q, fault_d;

   logic              wd_expired;

   assign wd_expired = (wd_q == WD_LAST);

   // Next-state, datapath and registered-output decode for the sequencer.
   always_comb begin
      state_d        = state_q;
      eip_d          = eip_q;
      next_eip_d     = next_eip_q;
      instr_len_d    = instr_len_q;
      retire_count_d = retire_count_q;
      wd_d           = wd_q;
      fault_code_d   = fault_code_q;

      case (state_q)
         S_IDLE, S_PAUSE: begin
            if (start) begin
               state_d = S_FETCH;
               wd_d    = '0;
            end
         end
         S_FETCH: begin
            if (fetch_ack) begin
               if (fetch_len == 4'd0) begin
                  state_d      = S_FAULT;
                  fault_code_d = FC_ZERO_LEN;
               end else if (fetch_halt) begin
                  state_d = S_HALT;
               end else begin
                  instr_len_d = fetch_len;
                  wd_d        = '0;
                  state_d     = S_EXEC;
               end
            end else if (wd_expired) begin
               state_d      = S_FAULT;
               fault_code_d = FC_FETCH_TO;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         S_EXEC: begin
            if (exec_done) begin
               next_eip_d = cfu_next_eip;
               state_d    = S_RETIRE;
            end else if (wd_expired) begin
               state_d      = S_FAULT;
               fault_code_d = FC_EXEC_TO;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         S_RETIRE: begin
            eip_d          = next_eip_q;
            retire_count_d = retire_count_q + 32'd1;
            wd_d           = '0;
            state_d        = single_step ? S_PAUSE : S_FETCH;
         end
         S_HALT, S_FAULT: begin
            state_d = state_q;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Outputs are registered from the next state so they line up with it.
      fetch_req_d = (state_d == S_FETCH);
      exec_req_d  = (state_d == S_EXEC);
      retired_d   = (state_d == S_RETIRE);
      halted_d    = (state_d == S_HALT);
      fault_d     = (state_d == S_FAULT);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         eip_q          <= RESET_EIP;
         next_eip_q     <= RESET_EIP;
         instr_len_q    <= '0;
         retire_count_q <= '0;
         wd_q           <= '0;
         fault_code_q   <= FC_NONE;
         fetch_req_q    <= 1'b0;
         exec_req_q     <= 1'b0;
         retired_q      <= 1'b0;
         halted_q       <= 1'b0;
         fault_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         eip_q          <= eip_d;
         next_eip_q     <= next_eip_d;
         instr_len_q    <= instr_len_d;
         retire_count_q <= retire_count_d;
         wd_q           <= wd_d;
         fault_code_q   <= fault_code_d;
         fetch_req_q    <= fetch_req_d;
         exec_req_q     <= exec_req_d;
         retired_q      <= retired_d;
         halted_q       <= halted_d;
         fault_q        <= fault_d;
      end
   end

   assign fetch_req    = fetch_req_q;
   assign fetch_addr   = eip_q;
   assign exec_req     = exec_req_q;
   assign eip          = eip_q;
   assign instr_len    = instr_len_q;
   assign retired      = retired_q;
   assign retire_count = retire_count_q;
   assign halted       = halted_q;
   assign fault        = fault_q;
   assign fault_code   = fault_code_q;

endmodule
